// File: rtl/stream_producer_pkg.sv
// Shared definitions for the xdrs core-to-core handshake (prdy/crdy/cerr/data).
// Holds the FSM state encodings, the default retry delay, the default width of
// the statistic counters and the data width. Other protocol blocks import this
// package as well.
package stream_producer_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SEND  = 2'd1;
  localparam logic [1:0] S_RETRY = 2'd2;

  localparam int DEF_RETRY_DELAY = 16;
  localparam int DEF_CNT_BW      = 32;
  localparam int DATA_W          = 32;

endpackage

// File: rtl/prod_fifo.sv
// Synchronous FIFO that buffers the producer's outgoing words.
// Ports: clk, rstn (async active-low); push/wdata write at the tail; pop
// advances the head; head_data is the combinational head word; count, full and
// empty report occupancy. A push while full and a pop while empty are ignored.
// Reset clears the storage, so head_data reads 0 out of reset.
module prod_fifo
  import stream_producer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = DATA_W
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [DW-1:0]            wdata,
  input  logic                     pop,
  output logic [DW-1:0]            head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][DW-1:0] mem;
  logic [AW-1:0]            wr_ptr, rd_ptr;
  logic                     do_push, do_pop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_data = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/stream_producer.sv
// Upstream producer end of the prdy/crdy/cerr handshake between cores.
// Ports: clk, rstn (async active-low); in_valid/in_data/in_ready is the local
// valid/ready source feeding the FIFO; p_prdy/p_data are offered to the
// consumer, p_crdy completes a transfer, p_cerr (while offered and not
// accepted) triggers a back-off of C_RETRY_DELAY cycles after which the same
// word is re-offered. sent_cnt counts transfers (wrapping); err_cnt counts
// retry entries (saturating).
module stream_producer
  import stream_producer_pkg::*;
#(
  parameter int C_FIFO_DEPTH  = 4,
  parameter int C_RETRY_DELAY = DEF_RETRY_DELAY,
  parameter int C_CNT_BW      = DEF_CNT_BW
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  output logic                in_ready,
  output logic                p_prdy,
  input  logic                p_crdy,
  input  logic                p_cerr,
  output logic [DATA_W-1:0]   p_data,
  output logic [C_CNT_BW-1:0] sent_cnt,
  output logic [C_CNT_BW-1:0] err_cnt
);

  localparam int CW = $clog2(C_FIFO_DEPTH) + 1;
  localparam int RW = $clog2(C_RETRY_DELAY);

  logic [1:0]    state, state_nx;
  logic [RW-1:0] rcnt;
  logic [CW-1:0] count;
  logic          full, empty;
  logic          push, pop, retry_done, enter_retry;

  assign in_ready    = ~full;
  assign push        = in_valid & in_ready;
  assign p_prdy      = (state == S_SEND);
  assign pop         = p_prdy & p_crdy;
  // p_crdy wins over p_cerr: an accepted word is never retried.
  assign enter_retry = p_prdy & ~p_crdy & p_cerr;
  assign retry_done  = (rcnt == RW'(C_RETRY_DELAY - 1));

  prod_fifo #(.DEPTH(C_FIFO_DEPTH), .DW(DATA_W)) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .wdata     (in_data),
    .pop       (pop),
    .head_data (p_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (!empty) state_nx = S_SEND;
      S_SEND: begin
        // Drop to idle only when the last word leaves with nothing arriving.
        if (p_crdy) begin
          if (count == CW'(1) && !push) state_nx = S_IDLE;
        end else if (p_cerr) begin
          state_nx = S_RETRY;
        end
      end
      S_RETRY: if (retry_done) state_nx = S_SEND;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      rcnt     <= '0;
      sent_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      state <= state_nx;
      // Counter runs 0..C_RETRY_DELAY-1 while in retry: exactly C_RETRY_DELAY
      // cycles with p_prdy low.
      if (state == S_RETRY) rcnt <= retry_done ? '0 : rcnt + RW'(1);
      else                  rcnt <= '0;
      if (pop) sent_cnt <= sent_cnt + C_CNT_BW'(1);
      if (enter_retry && (err_cnt != '1)) err_cnt <= err_cnt + C_CNT_BW'(1);
    end
  end

endmodule

// File: tb/tb_stream_producer.sv
module tb_stream_producer;
  logic        clk = 0;
  logic        rstn = 0;
  logic        in_valid = 0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        p_prdy;
  logic        p_crdy = 0;
  logic        p_cerr = 0;
  logic [31:0] p_data;
  logic [31:0] sent_cnt, err_cnt;

  int checks = 0;
  int fails  = 0;
  logic [31:0] exp_q[$];

  stream_producer dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .p_prdy(p_prdy), .p_crdy(p_crdy), .p_cerr(p_cerr),
    .p_data(p_data), .sent_cnt(sent_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one word for one edge; expected words go into the scoreboard.
  task automatic push_word(input logic [31:0] d, input bit expect_out);
    in_valid = 1;
    in_data  = d;
    if (expect_out) exp_q.push_back(d);
    tick();
    in_valid = 0;
  endtask

  // Monitor: a transfer happens at the next rising edge whenever the DUT
  // offers and the consumer accepts; inputs are stable at the falling edge.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rstn && p_prdy && p_crdy) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL xfer_unexpected: got 0x%08h expected no transfer", p_data);
        end else begin
          e = exp_q.pop_front();
          if (p_data !== e) begin
            fails++;
            $display("FAIL xfer_data: got 0x%08h expected 0x%08h", p_data, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int low;
    // Reset state
    tick(); tick();
    chk("rst_prdy", {31'b0, p_prdy}, 32'd0);
    chk("rst_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_data", p_data, 32'h0);
    chk("rst_sent", sent_cnt, 32'd0);
    chk("rst_err", err_cnt, 32'd0);
    rstn = 1;
    tick();

    // 1: single word latency
    p_crdy = 1;
    push_word(32'hA5A50001, 1);           // edge 1
    chk("s1_prdy_e1", {31'b0, p_prdy}, 32'd0);
    tick();                               // edge 2
    chk("s1_prdy_e2", {31'b0, p_prdy}, 32'd1);
    chk("s1_data", p_data, 32'hA5A50001);
    tick();                               // edge 3: transfer
    chk("s1_prdy_e3", {31'b0, p_prdy}, 32'd0);
    chk("s1_sent", sent_cnt, 32'd1);

    // 2: fill, overflow ignored, drain back-to-back
    p_crdy = 0;
    push_word(32'h1, 1); push_word(32'h2, 1); push_word(32'h3, 1); push_word(32'h4, 1);
    chk("s2_full", {31'b0, in_ready}, 32'd0);
    push_word(32'h5, 0);
    chk("s2_full_hold", {31'b0, in_ready}, 32'd0);
    chk("s2_prdy", {31'b0, p_prdy}, 32'd1);
    chk("s2_head", p_data, 32'h1);
    p_crdy = 1;
    tick();
    chk("s2_ready_after_pop", {31'b0, in_ready}, 32'd1);
    chk("s2_head2", p_data, 32'h2);
    chk("s2_prdy2", {31'b0, p_prdy}, 32'd1);
    tick(); tick(); tick();
    chk("s2_idle", {31'b0, p_prdy}, 32'd0);
    chk("s2_sent", sent_cnt, 32'd5);      // 1 + 4
    chk("s2_sb_empty", exp_q.size(), 32'd0);

    // 3: consumer error -> 16-cycle back-off, same word re-offered
    p_crdy = 0;
    push_word(32'hDEAD0000, 1);
    tick();
    chk("s3_prdy", {31'b0, p_prdy}, 32'd1);
    p_cerr = 1;
    tick();
    p_cerr = 0;
    low = 0;
    for (int i = 0; i < 40; i++) begin
      if (p_prdy) break;
      low++;
      tick();
    end
    chk("s3_low_cycles", low, 32'd16);
    chk("s3_data", p_data, 32'hDEAD0000);
    chk("s3_err", err_cnt, 32'd1);
    p_crdy = 1;
    tick();
    p_crdy = 0;
    chk("s3_sent", sent_cnt, 32'd6);
    chk("s3_prdy_after", {31'b0, p_prdy}, 32'd0);

    // 4: simultaneous push and pop at count 2
    push_word(32'h11, 1);
    push_word(32'h22, 1);
    in_valid = 1; in_data = 32'h55; exp_q.push_back(32'h55);
    p_crdy = 1;
    tick();
    in_valid = 0;
    chk("s4_head", p_data, 32'h22);
    chk("s4_prdy", {31'b0, p_prdy}, 32'd1);
    tick();
    chk("s4_head2", p_data, 32'h55);
    chk("s4_prdy2", {31'b0, p_prdy}, 32'd1);
    tick();
    chk("s4_idle", {31'b0, p_prdy}, 32'd0);
    chk("s4_sent", sent_cnt, 32'd9);
    p_crdy = 0;

    // 5: reset mid-retry with a full FIFO
    push_word(32'h100, 0); push_word(32'h101, 0); push_word(32'h102, 0); push_word(32'h103, 0);
    p_cerr = 1;
    tick();
    p_cerr = 0;
    tick(); tick(); tick(); tick();       // retry cycle 5
    chk("s5_err_before", err_cnt, 32'd2);
    rstn = 0;
    #1;
    chk("s5_prdy", {31'b0, p_prdy}, 32'd0);
    chk("s5_ready", {31'b0, in_ready}, 32'd1);
    chk("s5_data", p_data, 32'h0);
    chk("s5_sent", sent_cnt, 32'd0);
    chk("s5_err", err_cnt, 32'd0);
    in_valid = 1; in_data = 32'h99;       // ignored under reset
    tick();
    in_valid = 0;
    chk("s5_ready_rst", {31'b0, in_ready}, 32'd1);
    rstn = 1;
    tick();
    p_crdy = 1;
    push_word(32'h7, 1);
    chk("s5_prdy_e1", {31'b0, p_prdy}, 32'd0);
    tick();
    chk("s5_prdy_e2", {31'b0, p_prdy}, 32'd1);
    chk("s5_data7", p_data, 32'h7);
    tick();
    chk("s5_prdy_e3", {31'b0, p_prdy}, 32'd0);
    chk("s5_sent1", sent_cnt, 32'd1);

    // 6: crdy and cerr together -> transfer, no retry
    p_crdy = 0;
    push_word(32'h66, 1);
    tick();
    p_crdy = 1; p_cerr = 1;
    tick();
    p_crdy = 0; p_cerr = 0;
    chk("s6_prdy", {31'b0, p_prdy}, 32'd0);
    chk("s6_err", err_cnt, 32'd0);
    chk("s6_sent", sent_cnt, 32'd2);
    tick(); tick();
    chk("s6_prdy_stay", {31'b0, p_prdy}, 32'd0);
    chk("end_sb_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/stream_producer.md
Name: stream_producer

Overview:
- Upstream producer end of the core handshake (prdy/crdy/cerr/data) used between reconfigurable cores.
- Buffers 32-bit words from a local valid/ready source in a small FIFO.
- Presents the buffered words to a downstream core's consumer port.
- When the consumer signals a timeout error, backs off for a fixed retry delay and re-presents the same word.

Parameters:
- C_FIFO_DEPTH, 4, FIFO entries; power of two, >=2.
- C_RETRY_DELAY, 16, back-off cycles after p_cerr; range 2..256.
- C_CNT_BW, 32, width of the sent_cnt and err_cnt statistic counters.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream word valid.
- in_data  in  32  upstream word.
- in_ready  out  1  FIFO can accept a word (= not full).
- p_prdy  out  1  producer ready: p_data is valid this cycle.
- p_crdy  in  1  consumer ready; transfer occurs when p_prdy & p_crdy.
- p_cerr  in  1  consumer timeout error; meaningful only while p_prdy & ~p_crdy.
- p_data  out  32  FIFO head word.
- sent_cnt  out  C_CNT_BW  completed transfers, wraps modulo 2^C_CNT_BW.
- err_cnt  out  C_CNT_BW  retry entries, saturates at all-ones.

Behaviour:
- Reset (async, rstn low):
  - FIFO pointers and count = 0; state = S_IDLE; retry counter = 0; sent_cnt = err_cnt = 0.
  - p_prdy = 0; p_data = 0 (FIFO storage cleared); in_ready = 1.
  - in_valid is ignored while rstn is low.
- Push: in_valid & in_ready at a rising edge writes in_data at the tail.
- Pop: p_prdy & p_crdy at a rising edge advances the head.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers wrap modulo C_FIFO_DEPTH. Count width is log2(C_FIFO_DEPTH)+1.
- in_ready = (count != C_FIFO_DEPTH). in_valid while full is ignored, with no overwrite.
- p_data = storage[head], combinational from the head pointer. It is stable for the whole time a word is offered, including across retries.
- FSM, 2-bit registered state; p_prdy = (state == S_SEND):
  - S_IDLE: go to S_SEND if count != 0, else stay.
  - S_SEND:
    - If p_crdy: pop. Go to S_IDLE if count==1 and no push this edge; else stay in S_SEND (back-to-back words, one per cycle).
    - Else if p_cerr: go to S_RETRY and increment err_cnt.
    - Else stay.
    - p_crdy has priority over p_cerr.
  - S_RETRY:
    - p_prdy = 0. Retry counter increments each cycle.
    - When the counter == C_RETRY_DELAY-1: go to S_SEND and clear the counter.
    - Net effect: p_prdy is low for exactly C_RETRY_DELAY cycles. The word is not popped.
    - Pushes continue during S_RETRY.
- Latency: a word pushed into an empty FIFO at edge N gives p_prdy high after edge N+1. With p_crdy high it transfers at edge N+2.
- Reset asserted in any state, including mid-retry with a full FIFO: all content is discarded and everything returns to reset values immediately. The first post-reset push behaves as from cold.
- The counters increment only on their defined events. sent_cnt wraps; err_cnt holds at max.

Decomposition:
- Shared defines file (xdrs_defs) holds:
  - state encodings S_IDLE=2'd0, S_SEND=2'd1, S_RETRY=2'd2;
  - default retry delay 16;
  - default counter width 32.
  - Other protocol blocks reuse these.
- One sub-module: prod_fifo, a synchronous FIFO (C_FIFO_DEPTH x 32) with push, pop, head data, count, full, empty.
- The FSM, retry counter and statistic counters live in stream_producer.

Test Plan:
1. Reset, then push 0xA5A50001 at edge 1 with p_crdy=1 -> p_prdy high in the cycle after edge 2, p_data=0xA5A50001, transfer at edge 3, p_prdy low after, sent_cnt=1.
2. p_crdy=0, push 0x1,0x2,0x3,0x4 on consecutive edges -> in_ready=0 after the 4th push, a 5th in_valid is ignored. Then p_crdy=1 -> data 0x1,0x2,0x3,0x4 on 4 consecutive cycles, in_ready=1 after the first pop, sent_cnt=4.
3. Word 0xDEAD0000 offered, p_crdy=0, p_cerr pulsed for one cycle -> p_prdy low for exactly 16 cycles, then high with p_data still 0xDEAD0000, err_cnt=1. p_crdy=1 then transfers it, sent_cnt=1.
4. Count=2, push 0x55 and pop on the same edge (p_crdy=1) -> count stays 2, order preserved. The FSM stays in S_SEND until the FIFO drains, then goes to S_IDLE.
5. FIFO full and FSM in S_RETRY at cycle 5 of 16, rstn pulsed low -> immediately p_prdy=0, in_ready=1, p_data=0, sent_cnt=err_cnt=0. After release, a push of 0x7 follows scenario 1 timing.
6. Hold p_crdy=1 and p_cerr=1 together while a word is offered -> transfer happens, no retry, err_cnt unchanged.
